link_credit_rx: RTL and testbench
=================================

// Module: link_credit_rx
// PURPOSE
// - Receive end of a fixed-latency pipelined link: flits arrive DELAY cycles after launch.
// - Because of that latency the sender cannot see backpressure in time, so this block holds
//   in-flight flits in a DEPTH-entry circular buffer.
// - Presents buffered flits downstream on a valid/ready interface.
// - Emits one credit pulse per freed slot; the pulse travels back to the sender over a
//   matching delay line.
// PARAMETERS
// - WIDTH   32  flit data width in bits
// - DEPTH   8   buffer entries = credits the sender starts with; any value >= 2 (need not be a power of 2)
// PORTS
// - clk            in   1              clock
// - rst_n          in   1              asynchronous reset, active low
// - in_valid       in   1              flit present on link this cycle (no ready; cannot stall)
// - in_data        in   WIDTH          flit payload
// - out_valid      out  1              buffer non-empty; out_data holds head flit
// - out_ready      in   1              downstream accepts head flit this cycle
// - out_data       out  WIDTH          head flit payload
// - credit_return  out  1              one-cycle pulse per flit popped
// - overflow       out  1              sticky: a flit arrived with no free slot
// - occupancy      out  $clog2(DEPTH+1) current stored flit count
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, pointers 0, buffer contents don't-care.
// - Storage: wr_ptr and rd_ptr each count 0..DEPTH-1 and wrap explicitly to 0 after DEPTH-1.
//   Count register holds 0..DEPTH.
// - pop = out_valid && out_ready.
// - push = in_valid && (count < DEPTH || pop).
//   - A push is allowed while full if a pop occurs in the same cycle.
// - Latency: a flit pushed in cycle N is visible on out_valid/out_data in cycle N+1 at the
//   earliest. There is no combinational in->out path.
// - out_data and out_valid are driven from registered state only.
//   - out_data = mem[rd_ptr].
//   - out_valid = (count != 0).
// - Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
// - Empty buffer with in_valid: flit stored; out_valid rises next cycle; no same-cycle bypass.
// - credit_return is registered: asserted in cycle N+1 for each pop in cycle N. Back-to-back
//   pops give a continuous high level.
// - Drop case: in_valid && count == DEPTH && !pop.
//   - The flit is dropped; wr_ptr and count are unchanged.
//   - overflow is set next cycle and holds until rst_n is asserted.
//   - No credit is issued for the dropped flit.
// - out_ready while out_valid = 0: ignored; no pop, no credit.
// - Reset mid-operation: buffered flits are lost. The sender must reset on the same rst_n and
//   restart holding DEPTH credits.
// - occupancy equals the count register.
// CONFIGURATION
// - Macro LINK_CREDIT_RX_STATS_EN.
// - Defined: adds two outputs.
//   - rx_flits [31:0]: counts every push and wraps at 2^32.
//   - max_occupancy [$clog2(DEPTH+1)-1:0]: high-water mark of count.
//   - Both reset to 0 and update registered, in the cycle after the event.
//   - Dropped flits are not counted.
// - Undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
// - Single flit: A5A5_0001 in cycle 0, out_ready=1 -> out_valid=1 with A5A5_0001 in cycle 1;
//   credit_return=1 in cycle 2 only.
// - Fill: 8 consecutive flits 0..7, out_ready=0 -> occupancy=8, no credits, overflow=0.
//   Then hold out_ready=1 for 8 cycles -> data 0..7 in order, 8 consecutive credit pulses.
// - Full + simultaneous push/pop: with 8 stored, in_valid=1 (data 8) and out_ready=1 in the
//   same cycle -> 0 popped, 8 stored, occupancy stays 8, overflow=0.
// - Overflow: with 8 stored and out_ready=0, push data 99 -> overflow=1 next cycle and stays
//   set, occupancy=8, 99 never appears. Reset -> overflow=0.
// - Wrap-around: 20 random flits at random in_valid/out_ready (sender model holds 8 credits)
//   -> output order matches input order, pointers wrap past 7, credit count equals pop count.
// - Stats (macro defined): after the fill test -> max_occupancy=8, rx_flits=8. After the
//   overflow test -> rx_flits unchanged by the dropped flit.

Source files
------------

// File: rtl/link_credit_rx.sv
// link_credit_rx: receive end of a fixed-latency pipelined link.
// Flits land in a DEPTH-entry circular buffer because the sender cannot
// react to backpressure in time. The buffered flits are presented downstream
// on a valid/ready interface. Each popped flit returns one registered credit pulse.
// Optional build macro: LINK_CREDIT_RX_STATS_EN adds the rx_flits and
// max_occupancy statistics outputs.
module link_credit_rx #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       credit_return,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef LINK_CREDIT_RX_STATS_EN
    ,
    output logic [31:0]                rx_flits,
    output logic [$clog2(DEPTH+1)-1:0] max_occupancy
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage: data array is never reset, only the control around it.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;

    logic full;
    logic push;
    logic pop;
    logic drop;

    logic credit_p1;
    logic overflow_p1;

`ifdef LINK_CREDIT_RX_STATS_EN
    logic [31:0]   rx_flits_p1;
    logic [CW-1:0] max_occ_p1;
`endif

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Handshake decode and next occupancy; a full buffer still accepts a
    // flit when the head leaves in the same cycle.
    always_comb begin
        full      = (count == CW'(DEPTH));
        pop       = (count != '0) && out_ready;
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Control state: pointers, count, credit pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            credit_p1   <= 1'b0;
            overflow_p1 <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count     <= count_nxt;
            credit_p1 <= pop;
            if (drop) begin
                overflow_p1 <= 1'b1;
            end
        end
    end

    // Flit write into the slot under wr_ptr; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef LINK_CREDIT_RX_STATS_EN
    // Statistics: accepted-flit counter and high-water mark of occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_flits_p1 <= '0;
            max_occ_p1  <= '0;
        end else begin
            if (push) begin
                rx_flits_p1 <= rx_flits_p1 + 32'd1;
            end
            if (count_nxt > max_occ_p1) begin
                max_occ_p1 <= count_nxt;
            end
        end
    end

    assign rx_flits      = rx_flits_p1;
    assign max_occupancy = max_occ_p1;
`endif

    // Outputs come straight from registered state; no in->out bypass.
    assign out_valid     = (count != '0);
    assign out_data      = mem[rd_ptr];
    assign credit_return = credit_p1;
    assign overflow      = overflow_p1;
    assign occupancy     = count;

endmodule

// File: tb/tb_link_credit_rx.sv
// Bench for link_credit_rx: table of directed cycles plus hand-written
// sequences for overflow/reset and a credit-limited randomized ordering run.
module tb_link_credit_rx;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             credit_return;
    logic             overflow;
    logic [CW-1:0]    occupancy;
`ifdef LINK_CREDIT_RX_STATS_EN
    logic [31:0]      rx_flits;
    logic [CW-1:0]    max_occupancy;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    link_credit_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .credit_return (credit_return),
        .overflow      (overflow),
        .occupancy     (occupancy)
`ifdef LINK_CREDIT_RX_STATS_EN
        ,
        .rx_flits      (rx_flits),
        .max_occupancy (max_occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = expected outputs at the start of a cycle, then inputs for it.
    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        rdy;
        logic        eov;
        logic [31:0] edata;
        logic        ecr;
        logic        eof;
        int          eocc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic iv, input logic [31:0] d, input logic rdy,
                                input logic eov, input logic [31:0] edata, input logic ecr,
                                input logic eof, input int eocc);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy;
        v.eov = eov; v.edata = edata; v.ecr = ecr; v.eof = eof; v.eocc = eocc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_credit", credit_return, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_occupancy", occupancy, 0);
`ifdef LINK_CREDIT_RX_STATS_EN
        chk("rst_rx_flits", rx_flits, 0);
        chk("rst_max_occ", max_occupancy, 0);
`endif
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int sent, popped, returned, credits, cyc;
        logic [31:0] q[$];
        logic [31:0] d;
        logic        rdy;

        // Single flit.
        add(1, 32'hA5A5_0001, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 32'hA5A5_0001, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Fill with 0..7, no drain.
        for (int k = 0; k < 8; k++) add(1, k, 0, k > 0, 0, 0, 0, k);
        add(0, 0, 0, 1, 0, 0, 0, 8);
        // Drain 0..7 in order with a continuous run of credits.
        for (int k = 0; k < 8; k++) add(0, 0, 1, 1, k, k > 0, 0, 8 - k);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Refill 100..107, then push 8 while popping when full.
        for (int k = 0; k < 8; k++) add(1, 100 + k, 0, k > 0, 100, 0, 0, k);
        add(1, 8, 1, 1, 100, 0, 0, 8);
        for (int k = 0; k < 8; k++) add(0, 0, 1, 1, (k < 7) ? 101 + k : 8, 1, 0, 8 - k);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // out_ready on an empty buffer: no pop, no credit.
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Streaming push+pop at occupancy 1.
        add(1, 200, 1, 0, 0, 0, 0, 0);
        add(1, 201, 1, 1, 200, 0, 0, 1);
        add(0, 0, 1, 1, 201, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);

        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("r%0d_out_valid", i), out_valid, tbl[i].eov);
            if (tbl[i].eov) chk($sformatf("r%0d_out_data", i), out_data, tbl[i].edata);
            chk($sformatf("r%0d_credit", i), credit_return, tbl[i].ecr);
            chk($sformatf("r%0d_overflow", i), overflow, tbl[i].eof);
            chk($sformatf("r%0d_occupancy", i), occupancy, tbl[i].eocc);
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].rdy;
            step();
        end
`ifdef LINK_CREDIT_RX_STATS_EN
        chk("tbl_rx_flits", rx_flits, 20);
        chk("tbl_max_occ", max_occupancy, 8);
`endif

        // Overflow: fill, then a dropped flit 99; sticky until reset.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = k; out_ready = 1'b0;
            step();
        end
        chk("fill_occ", occupancy, 8);
        chk("fill_overflow", overflow, 0);
`ifdef LINK_CREDIT_RX_STATS_EN
        chk("fill_rx_flits", rx_flits, 8);
        chk("fill_max_occ", max_occupancy, 8);
`endif
        in_valid = 1'b1; in_data = 99;
        step();
        in_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_occ", occupancy, 8);
        chk("ovf_credit", credit_return, 0);
`ifdef LINK_CREDIT_RX_STATS_EN
        chk("ovf_rx_flits", rx_flits, 8);
`endif
        for (int k = 0; k < 3; k++) step();
        chk("ovf_sticky", overflow, 1);
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'b1;
            chk($sformatf("ovf_drain%0d", k), out_data, k);
            step();
        end
        out_ready = 1'b0;
        chk("ovf_empty", out_valid, 0);
        chk("ovf_still_set", overflow, 1);
        do_reset();
        chk("ovf_cleared", overflow, 0);

        // Credit-limited random traffic; ordering and credit accounting.
        sent = 0; popped = 0; returned = 0; credits = DEPTH; cyc = 0;
        while ((sent < 20 || popped < 20) && cyc < 1000) begin
            if (credit_return) begin
                returned++;
                credits++;
            end
            rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_pop", out_valid, 0);
                end else begin
                    d = q.pop_front();
                    chk($sformatf("rnd_data%0d", popped), out_data, d);
                end
                popped++;
            end
            in_valid = 1'b0;
            if (sent < 20 && credits > 0 && $urandom_range(0, 1) == 1) begin
                d = $urandom;
                in_valid = 1'b1;
                in_data  = d;
                q.push_back(d);
                credits--;
                sent++;
            end
            step();
            cyc++;
        end
        if (cyc >= 1000) chk("rnd_timeout", cyc, 0);
        for (int k = 0; k < 3; k++) begin
            if (credit_return) returned++;
            in_valid = 1'b0; out_ready = 1'b0;
            step();
        end
        chk("rnd_credits_eq_pops", returned, popped);
        chk("rnd_overflow", overflow, 0);
        chk("rnd_occ", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
